// File: rtl/pipelined_exe_if.sv
// ID -> EXE boundary bundle for the execute stage.
// The ID side drives decoded controls, operands and the Stall request;
// the EXE side returns the registered slot contents, the ALU result and
// the instruction/bubble counters.
interface pipelined_exe_if;
    // ID-side decoded controls and operands
    logic        ID_Wreg;
    logic        ID_Reg2reg;
    logic        ID_Wmem;
    logic        ID_Aluqb;
    logic [1:0]  ID_Aluc;
    logic [31:0] ID_Qa;
    logic [31:0] ID_Qb;
    logic [31:0] ID_Ext_imm;
    logic [4:0]  ID_write_reg;
    logic        Stall;

    // EXE-side slot contents
    logic        EXE_Wreg;
    logic        EXE_Reg2reg;
    logic        EXE_Wmem;
    logic [4:0]  EXE_write_reg;
    logic [31:0] EXE_Alu;
    logic [31:0] EXE_Qb;
    logic        EXE_Valid;
    logic [31:0] Bubble_cnt;
    logic [31:0] Inst_cnt;

    // Master: the ID stage (or a bench standing in for it)
    modport master (
        output ID_Wreg, ID_Reg2reg, ID_Wmem, ID_Aluqb, ID_Aluc,
               ID_Qa, ID_Qb, ID_Ext_imm, ID_write_reg, Stall,
        input  EXE_Wreg, EXE_Reg2reg, EXE_Wmem, EXE_write_reg,
               EXE_Alu, EXE_Qb, EXE_Valid, Bubble_cnt, Inst_cnt
    );

    // Slave: the execute stage itself
    modport slave (
        input  ID_Wreg, ID_Reg2reg, ID_Wmem, ID_Aluqb, ID_Aluc,
               ID_Qa, ID_Qb, ID_Ext_imm, ID_write_reg, Stall,
        output EXE_Wreg, EXE_Reg2reg, EXE_Wmem, EXE_write_reg,
               EXE_Alu, EXE_Qb, EXE_Valid, Bubble_cnt, Inst_cnt
    );
endinterface

// File: rtl/pipelined_exe.sv
// Execute stage of a 5-stage pipeline: ID/EXE register, 4-function ALU,
// and bubble/instruction counters. A stall from ID turns the loaded slot
// into a bubble whose data fields are all zero, so the ALU reads 0.
// Results are exported straight from the slot so the ID stage can forward
// and detect load-use hazards in the same cycle.
module pipelined_exe (
    input  logic           Clk,
    input  logic           Clrn,
    pipelined_exe_if.slave bus
);

    // Slot occupancy: EMPTY holds a bubble, FULL a real instruction.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    slot_state_t state_reg;
    slot_state_t state_next;

    // ID/EXE register fields
    logic        wreg_reg,      wreg_next;
    logic        reg2reg_reg,   reg2reg_next;
    logic        wmem_reg,      wmem_next;
    logic        aluqb_reg,     aluqb_next;
    logic [1:0]  aluc_reg,      aluc_next;
    logic [31:0] qa_reg,        qa_next;
    logic [31:0] qb_reg,        qb_next;
    logic [31:0] ext_imm_reg,   ext_imm_next;
    logic [4:0]  write_reg_reg, write_reg_next;

    // Counters
    logic [31:0] inst_cnt_reg,   inst_cnt_next;
    logic [31:0] bubble_cnt_reg, bubble_cnt_next;

    // ALU datapath
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_sum;
    logic [31:0] alu_diff;
    logic [31:0] alu_and;
    logic [31:0] alu_or;
    logic [31:0] alu_result;

    // Slot state register; reset leaves the slot empty.
    always_ff @(posedge Clk or posedge Clrn) begin
        if (Clrn) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next slot state: any stall inserts a bubble, otherwise the slot fills.
    always_comb begin
        state_next = state_reg;
        if (bus.Stall) begin
            state_next = EMPTY;
        end else begin
            state_next = FULL;
        end
    end

    // Next slot contents: capture ID fields, or a zeroed bubble on stall.
    // A bubble keeps Aluqb=1 so operand b is the zeroed Qb, matching reset.
    always_comb begin
        wreg_next      = bus.ID_Wreg;
        reg2reg_next   = bus.ID_Reg2reg;
        wmem_next      = bus.ID_Wmem;
        aluqb_next     = bus.ID_Aluqb;
        aluc_next      = bus.ID_Aluc;
        qa_next        = bus.ID_Qa;
        qb_next        = bus.ID_Qb;
        ext_imm_next   = bus.ID_Ext_imm;
        write_reg_next = bus.ID_write_reg;
        if (bus.Stall) begin
            wreg_next      = 1'b0;
            reg2reg_next   = 1'b0;
            wmem_next      = 1'b0;
            aluqb_next     = 1'b1;
            aluc_next      = ALU_ADD;
            qa_next        = 32'd0;
            qb_next        = 32'd0;
            ext_imm_next   = 32'd0;
            write_reg_next = 5'd0;
        end
    end

    // ID/EXE register; reset discards any in-flight instruction so no
    // write enable survives into the next stage.
    always_ff @(posedge Clk or posedge Clrn) begin
        if (Clrn) begin
            wreg_reg      <= 1'b0;
            reg2reg_reg   <= 1'b0;
            wmem_reg      <= 1'b0;
            aluqb_reg     <= 1'b1;
            aluc_reg      <= ALU_ADD;
            qa_reg        <= 32'd0;
            qb_reg        <= 32'd0;
            ext_imm_reg   <= 32'd0;
            write_reg_reg <= 5'd0;
        end else begin
            wreg_reg      <= wreg_next;
            reg2reg_reg   <= reg2reg_next;
            wmem_reg      <= wmem_next;
            aluqb_reg     <= aluqb_next;
            aluc_reg      <= aluc_next;
            qa_reg        <= qa_next;
            qb_reg        <= qb_next;
            ext_imm_reg   <= ext_imm_next;
            write_reg_reg <= write_reg_next;
        end
    end

    // Counter next values: exactly one of the two advances on every edge,
    // both wrap naturally at 2^32.
    always_comb begin
        inst_cnt_next   = inst_cnt_reg;
        bubble_cnt_next = bubble_cnt_reg;
        if (bus.Stall) begin
            bubble_cnt_next = bubble_cnt_reg + 32'd1;
        end else begin
            inst_cnt_next = inst_cnt_reg + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge Clk or posedge Clrn) begin
        if (Clrn) begin
            inst_cnt_reg   <= 32'd0;
            bubble_cnt_reg <= 32'd0;
        end else begin
            inst_cnt_reg   <= inst_cnt_next;
            bubble_cnt_reg <= bubble_cnt_next;
        end
    end

    // Operand selection: b is the register operand or the immediate.
    assign alu_a    = qa_reg;
    assign alu_b    = aluqb_reg ? qb_reg : ext_imm_reg;
    assign alu_sum  = alu_a + alu_b;
    assign alu_diff = alu_a - alu_b;

    // Bitwise logic unit, one slice per bit.
    for (genvar gi = 0; gi < 32; gi++) begin : g_logic_slice
        assign alu_and[gi] = alu_a[gi] & alu_b[gi];
        assign alu_or[gi]  = alu_a[gi] | alu_b[gi];
    end

    // ALU function select, purely combinational from the slot.
    always_comb begin
        alu_result = 32'd0;
        case (aluc_reg)
            ALU_ADD: alu_result = alu_sum;
            ALU_SUB: alu_result = alu_diff;
            ALU_AND: alu_result = alu_and;
            ALU_OR:  alu_result = alu_or;
            default: alu_result = 32'd0;
        endcase
    end

    // Slot exports, unregistered beyond the ID/EXE register.
    assign bus.EXE_Wreg      = wreg_reg;
    assign bus.EXE_Reg2reg   = reg2reg_reg;
    assign bus.EXE_Wmem      = wmem_reg;
    assign bus.EXE_write_reg = write_reg_reg;
    assign bus.EXE_Alu       = alu_result;
    assign bus.EXE_Qb        = qb_reg;
    assign bus.EXE_Valid     = (state_reg == FULL);
    assign bus.Inst_cnt      = inst_cnt_reg;
    assign bus.Bubble_cnt    = bubble_cnt_reg;

endmodule

// File: tb/tb_pipelined_exe.sv
// Directed bench for the execute stage: ALU functions, immediate path,
// stall bubbles, asynchronous reset mid-operation and counter wrap.
module tb_pipelined_exe;

    logic Clk;
    logic Clrn;
    int   tests_run;
    int   tests_failed;

    pipelined_exe_if bus ();

    pipelined_exe dut (
        .Clk  (Clk),
        .Clrn (Clrn),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic wreg, input logic reg2reg, input logic wmem,
                         input logic aluqb, input logic [1:0] aluc,
                         input logic [31:0] qa, input logic [31:0] qb,
                         input logic [31:0] ext_imm, input logic [4:0] write_reg,
                         input logic stall);
        bus.ID_Wreg      = wreg;
        bus.ID_Reg2reg   = reg2reg;
        bus.ID_Wmem      = wmem;
        bus.ID_Aluqb     = aluqb;
        bus.ID_Aluc      = aluc;
        bus.ID_Qa        = qa;
        bus.ID_Qb        = qb;
        bus.ID_Ext_imm   = ext_imm;
        bus.ID_write_reg = write_reg;
        bus.Stall        = stall;
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        Clrn = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 32'h1234, 32'h5678, 32'h9, 5'd7, 1'b0);
        #2;
        // Reset state, before any clock edge
        check("rst_wreg",   {31'd0, bus.EXE_Wreg},   32'd0);
        check("rst_wmem",   {31'd0, bus.EXE_Wmem},   32'd0);
        check("rst_valid",  {31'd0, bus.EXE_Valid},  32'd0);
        check("rst_alu",    bus.EXE_Alu,             32'd0);
        check("rst_qb",     bus.EXE_Qb,              32'd0);
        check("rst_inst",   bus.Inst_cnt,            32'd0);
        check("rst_bubble", bus.Bubble_cnt,          32'd0);
        step();
        check("rst_held_alu", bus.EXE_Alu, 32'd0);
        Clrn = 1'b0;

        // ADD 5+7 -> r3
        drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 32'd5, 32'd7, 32'd0, 5'd3, 1'b0);
        step();
        check("add_alu",    bus.EXE_Alu,                  32'd12);
        check("add_wr",     {27'd0, bus.EXE_write_reg},   32'd3);
        check("add_wreg",   {31'd0, bus.EXE_Wreg},        32'd1);
        check("add_valid",  {31'd0, bus.EXE_Valid},       32'd1);
        check("add_inst",   bus.Inst_cnt,                 32'd1);
        check("add_bubble", bus.Bubble_cnt,               32'd0);

        // SUB 0-1 wraps
        drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 32'd0, 32'd1, 32'd0, 5'd4, 1'b0);
        step();
        check("sub_alu",  bus.EXE_Alu,  32'hFFFF_FFFF);
        check("sub_inst", bus.Inst_cnt, 32'd2);

        // AND, then OR
        drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 5'd5, 1'b0);
        step();
        check("and_alu", bus.EXE_Alu, 32'h0000_F000);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 5'd6, 1'b0);
        step();
        check("or_alu",  bus.EXE_Alu, 32'h0000_FFF0);
        check("or_inst", bus.Inst_cnt, 32'd4);

        // sw: immediate operand, store data from Qb
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h100, 32'hAB, 32'hFFFF_FFFC, 5'd0, 1'b0);
        step();
        check("sw_alu",  bus.EXE_Alu,              32'h0000_00FC);
        check("sw_qb",   bus.EXE_Qb,               32'h0000_00AB);
        check("sw_wmem", {31'd0, bus.EXE_Wmem},    32'd1);
        check("sw_wreg", {31'd0, bus.EXE_Wreg},    32'd0);

        // lw held by two stall edges
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 32'h200, 32'h0, 32'h8, 5'd9, 1'b1);
        step();
        check("stall1_valid",  {31'd0, bus.EXE_Valid}, 32'd0);
        check("stall1_wreg",   {31'd0, bus.EXE_Wreg},  32'd0);
        check("stall1_wmem",   {31'd0, bus.EXE_Wmem},  32'd0);
        check("stall1_alu",    bus.EXE_Alu,            32'd0);
        check("stall1_bubble", bus.Bubble_cnt,         32'd1);
        step();
        check("stall2_valid",  {31'd0, bus.EXE_Valid}, 32'd0);
        check("stall2_alu",    bus.EXE_Alu,            32'd0);
        check("stall2_wr",     {27'd0, bus.EXE_write_reg}, 32'd0);
        check("stall2_bubble", bus.Bubble_cnt,         32'd2);
        check("stall2_inst",   bus.Inst_cnt,           32'd5);
        bus.Stall = 1'b0;
        step();
        check("lw_alu",     bus.EXE_Alu,                32'h208);
        check("lw_wreg",    {31'd0, bus.EXE_Wreg},      32'd1);
        check("lw_reg2reg", {31'd0, bus.EXE_Reg2reg},   32'd1);
        check("lw_wr",      {27'd0, bus.EXE_write_reg}, 32'd9);
        check("lw_valid",   {31'd0, bus.EXE_Valid},     32'd1);
        check("lw_inst",    bus.Inst_cnt,               32'd6);
        check("lw_bubble",  bus.Bubble_cnt,             32'd2);

        // Async reset pulsed between edges while EXE_Wreg=1
        #2;
        Clrn = 1'b1;
        #1;
        check("arst_wreg",    {31'd0, bus.EXE_Wreg},    32'd0);
        check("arst_reg2reg", {31'd0, bus.EXE_Reg2reg}, 32'd0);
        check("arst_valid",   {31'd0, bus.EXE_Valid},   32'd0);
        check("arst_alu",     bus.EXE_Alu,              32'd0);
        check("arst_inst",    bus.Inst_cnt,             32'd0);
        check("arst_bubble",  bus.Bubble_cnt,           32'd0);
        Clrn = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 32'd1, 32'd2, 32'd0, 5'd4, 1'b0);
        step();
        check("post_rst_alu",   bus.EXE_Alu,                32'd3);
        check("post_rst_wr",    {27'd0, bus.EXE_write_reg}, 32'd4);
        check("post_rst_inst",  bus.Inst_cnt,               32'd1);
        check("post_rst_valid", {31'd0, bus.EXE_Valid},     32'd1);

        // Instruction counter wrap
        force dut.inst_cnt_reg = 32'hFFFF_FFFF;
        #1;
        release dut.inst_cnt_reg;
        #1;
        check("wrap_pre", bus.Inst_cnt, 32'hFFFF_FFFF);
        step();
        check("wrap_inst",   bus.Inst_cnt,   32'd0);
        check("wrap_bubble", bus.Bubble_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipelined_exe.md
PIPELINED_EXE -- requirements
Module: pipelined_exe

Interface
REQ-001 The port Clk SHALL be an input, 1 bit wide, and SHALL be the single clock; all state SHALL update on its rising edge.
REQ-002 The port Clrn SHALL be an input, 1 bit wide, and SHALL be an asynchronous, active-high reset (1 = clear).
REQ-003 The ID-side inputs SHALL be:
- ID_Wreg, ID_Reg2reg, ID_Wmem, ID_Aluqb: 1 bit each, the decoded controls from the ID stage.
- ID_Aluc: 2 bits, the ALU operation.
- ID_Qa, ID_Qb, ID_Ext_imm: 32 bits each, forwarded operands and the extended immediate.
- ID_write_reg: 5 bits, the destination register number.
REQ-004 The input Stall SHALL be 1 bit; when 1, the ID stage holds its instruction and this block SHALL load a bubble.
REQ-005 The EXE-side outputs SHALL be:
- EXE_Wreg, EXE_Reg2reg, EXE_Wmem: 1 bit each, the registered controls.
- EXE_write_reg: 5 bits, the registered destination register.
- EXE_Alu: 32 bits, the ALU result.
- EXE_Qb: 32 bits, the registered store data.
REQ-006 The output EXE_Valid SHALL be 1 bit and SHALL be 1 when the EXE slot holds a real instruction (0 for a bubble).
REQ-007 The outputs Bubble_cnt and Inst_cnt SHALL be 32 bits each and SHALL count bubbles and real instructions that enter EXE.

Function
REQ-008 The ID/EXE register SHALL capture all ID_* inputs on each rising Clk edge when Stall=0, and SHALL set EXE_Valid to 1.
REQ-009 When Stall=1, the block SHALL load a bubble at the edge: Wreg=0, Wmem=0, Reg2reg=0, write_reg=0, Aluc=00, Aluqb=1, Qa=0, Qb=0, Ext_imm=0, EXE_Valid=0.
REQ-010 Data fields of a bubble SHALL be zero, so EXE_Alu evaluates to 0 during a bubble cycle.
REQ-011 The ALU operand a SHALL be the registered Qa.
REQ-012 The ALU operand b SHALL be the registered Qb when Aluqb=1, and the registered Ext_imm when Aluqb=0.
REQ-013 EXE_Alu SHALL be combinational from the registered state, with zero cycles of latency from the register:
- Aluc=00: a+b.
- Aluc=01: a-b.
- Aluc=10: a AND b.
- Aluc=11: a OR b.
REQ-014 Addition and subtraction SHALL be 32-bit modulo 2^32: carry and overflow are discarded, and no trap is raised.
REQ-015 EXE_Qb SHALL always equal the registered Qb, independent of Aluqb, for use as store data.
REQ-016 Total latency from ID inputs to EXE outputs SHALL be exactly one Clk edge.
REQ-017 Inst_cnt SHALL increment by 1 on each edge that loads a real instruction (Stall=0).
REQ-018 Bubble_cnt SHALL increment by 1 on each edge that loads a bubble (Stall=1).
REQ-019 On every edge outside reset, exactly one of Inst_cnt and Bubble_cnt SHALL increment.
REQ-020 Both counters SHALL wrap from 0xFFFFFFFF to 0x00000000 without saturating or flagging.
REQ-021 The block SHALL have a two-state slot state machine, EMPTY (EXE_Valid=0) and FULL (EXE_Valid=1):
- Any state, Stall=0 -> FULL.
- Any state, Stall=1 -> EMPTY.
- Reset -> EMPTY.
REQ-022 When Stall is held high for N consecutive edges, the block SHALL insert N consecutive bubbles, and Bubble_cnt SHALL advance by N.
REQ-023 Forwarding selection SHALL NOT be performed in this block; EXE_Alu, EXE_write_reg, EXE_Wreg and EXE_Reg2reg SHALL be exported unregistered from the slot so that the ID stage can forward and detect load-use hazards in the same cycle.

Reset
REQ-024 While Clrn=1, all registered fields SHALL be 0 immediately (asynchronously): EXE_Wreg=0, EXE_Reg2reg=0, EXE_Wmem=0, EXE_write_reg=0, EXE_Qb=0, EXE_Valid=0, Aluc=00, Aluqb=1.
REQ-025 While Clrn=1, Bubble_cnt and Inst_cnt SHALL both be 0.
REQ-026 With the reset values of REQ-024, EXE_Alu SHALL read 0 during reset.
REQ-027 Reset asserted mid-operation SHALL discard the in-flight instruction, with no write-enable pulse escaping.
REQ-028 The first edge after Clrn falls SHALL be processed normally according to Stall.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- ADD: Qa=5, Qb=7, Aluqb=1, Aluc=00, Wreg=1, write_reg=3, Stall=0 -> next cycle EXE_Alu=12, EXE_write_reg=3, EXE_Wreg=1, EXE_Valid=1, Inst_cnt=1.
- SUB wrap: Qa=0, Qb=1, Aluc=01, Aluqb=1 -> EXE_Alu=0xFFFFFFFF.
- Immediate path (sw): Qa=0x100, Ext_imm=0xFFFFFFFC, Qb=0xAB, Aluqb=0, Aluc=00, Wmem=1 -> EXE_Alu=0xFC, EXE_Qb=0xAB, EXE_Wmem=1.
- Stall: valid lw instruction with Stall=1 for 2 edges -> two cycles of EXE_Valid=0, Wreg=0, Wmem=0, EXE_Alu=0; Bubble_cnt=2; Inst_cnt unchanged; then Stall=0 loads the instruction.
- Async reset mid-op: Clrn pulsed between edges while EXE_Wreg=1 -> EXE_Wreg=0 and both counters=0 before the next edge; the first edge after release loads normally.
- Counter wrap: force Inst_cnt to 0xFFFFFFFF, one real instruction -> Inst_cnt=0.
